// File: rtl/psram_define.sv
// rtl/psram_define.sv - shared PSRAM definitions: rx capture FSM encodings and FIFO entry layout
package psram_define;

    localparam logic [1:0] PSRAM_RX_FSM_IDLE  = 2'd0;
    localparam logic [1:0] PSRAM_RX_FSM_WAIT  = 2'd1;
    localparam logic [1:0] PSRAM_RX_FSM_CAPT  = 2'd2;
    localparam logic [1:0] PSRAM_RX_FSM_FLUSH = 2'd3;

    localparam int PSRAM_RX_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        RX_IDLE  = PSRAM_RX_FSM_IDLE,
        RX_WAIT  = PSRAM_RX_FSM_WAIT,
        RX_CAPT  = PSRAM_RX_FSM_CAPT,
        RX_FLUSH = PSRAM_RX_FSM_FLUSH
    } psram_rx_state_e;

    typedef struct packed {
        logic                                last;
        logic [PSRAM_RX_WORD_WIDTH/8-1:0]    strb;
        logic [PSRAM_RX_WORD_WIDTH-1:0]      data;
    } psram_rx_entry_t;

endpackage

// File: rtl/psram_rx_fifo.sv
// rtl/psram_rx_fifo.sv - synchronous word FIFO; a pop frees the slot for a same-cycle push
module psram_rx_fifo
    import psram_define::*;
#(
    parameter int WIDTH = PSRAM_RX_WORD_WIDTH + PSRAM_RX_WORD_WIDTH/8 + 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + (AW+1)'(1);
            if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/psram_rx_capture.sv
// rtl/psram_rx_capture.sv - OPI read-data capture: latency skip, little-endian word packing, FIFO output
module psram_rx_capture
    import psram_define::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [7:0]           lat_i,
    input  logic                 abort_i,
    input  logic                 sck_edge_i,
    input  logic [7:0]           psram_io_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o,
    output logic [31:0]          data_o,
    output logic [3:0]           strb_o,
    output logic                 last_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    psram_rx_state_e      state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [7:0]           lat_q, lat_d;
    logic [1:0]           idx_q, idx_d;
    logic [31:0]          asm_q, asm_d;
    logic [3:0]           lanes_q, lanes_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 push;
    psram_rx_entry_t      push_entry;
    psram_rx_entry_t      head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [31:0]          word_v;
    logic [3:0]           lanes_v;

    assign pop = !fifo_empty && ready_i;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        lat_d      = lat_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        lanes_d    = lanes_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        push       = 1'b0;
        push_entry = '0;
        word_v     = asm_q;
        lanes_v    = lanes_q;

        case (state_q)
            RX_IDLE: begin
                if (start_i) begin
                    ovf_d = 1'b0;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = len_i;
                        lat_d   = lat_i;
                        idx_d   = 2'd0;
                        asm_d   = '0;
                        lanes_d = '0;
                        state_d = (lat_i != 8'd0) ? RX_WAIT : RX_CAPT;
                    end
                end
            end
            RX_WAIT: begin
                if (abort_i) begin
                    state_d = RX_FLUSH;
                end else if (sck_edge_i && lat_q != 8'd0) begin
                    lat_d = lat_q - 8'd1;
                    if (lat_q == 8'd1) state_d = RX_CAPT;
                end
            end
            RX_CAPT: begin
                // Abort beats a coincident strobe, so that byte never reaches the word
                if (abort_i) begin
                    state_d = RX_FLUSH;
                end else if (sck_edge_i && rem_q != '0) begin
                    word_v[{idx_q, 3'b000} +: 8] = psram_io_in_i;
                    lanes_v = lanes_q | (4'b0001 << idx_q);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3 || rem_d == '0) begin
                        push       = 1'b1;
                        push_entry = '{last: (rem_d == '0), strb: lanes_v, data: word_v};
                        asm_d      = '0;
                        lanes_d    = '0;
                    end else begin
                        asm_d   = word_v;
                        lanes_d = lanes_v;
                    end
                    if (rem_d == '0) begin
                        state_d = RX_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RX_FLUSH: begin
                if (lanes_q != 4'd0) begin
                    push       = 1'b1;
                    push_entry = '{last: 1'b1, strb: lanes_q, data: asm_q};
                end
                asm_d   = '0;
                lanes_d = '0;
                state_d = RX_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase

        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            rem_q   <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            lanes_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            lanes_q <= lanes_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    psram_rx_fifo #(
        .WIDTH ($bits(psram_rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy_o  = (state_q != RX_IDLE);
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;
    assign valid_o = !fifo_empty;
    assign data_o  = head.data;
    assign strb_o  = head.strb;
    assign last_o  = head.last;

endmodule

// File: tb/tb_psram_rx_capture.sv
// tb/tb_psram_rx_capture.sv - directed self-checking bench for psram_rx_capture
module tb_psram_rx_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [7:0]  lat = 8'd0;
    logic        abort = 1'b0;
    logic        sck_edge = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        ready = 1'b0;
    logic        busy_o, done_o, ovf_o, last_o, valid_o;
    logic [31:0] data_o;
    logic [3:0]  strb_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psram_rx_capture #(.FIFO_DEPTH(4), .LEN_WIDTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .len_i         (len),
        .lat_i         (lat),
        .abort_i       (abort),
        .sck_edge_i    (sck_edge),
        .psram_io_in_i (din),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ovf_o         (ovf_o),
        .data_o        (data_o),
        .strb_o        (strb_o),
        .last_o        (last_o),
        .valid_o       (valid_o),
        .ready_i       (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sck(input logic [7:0] d);
        sck_edge = 1'b1;
        din      = d;
        tick();
        sck_edge = 1'b0;
    endtask

    task automatic go(input logic [7:0] l, input logic [7:0] w);
        start = 1'b1;
        len   = l;
        lat   = w;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] seq_word(input int k);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*k);
        b1 = 8'(4*k+1);
        b2 = 8'(4*k+2);
        b3 = 8'(4*k+3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if ({last_o, strb_o, data_o} !== 37'd0) begin errors++; $display("FAIL reset_head: got %h expected 0", {last_o, strb_o, data_o}); end
    endtask

    task automatic test_lat2();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        go(8'd4, 8'd2);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL lat2_busy_start: got %b expected 1", busy_o); end
        sck(8'hEE);
        sck(8'hEF);
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL lat2_span%0d: got busy=%b done=%b valid=%b expected 1 0 0", i, busy_o, done_o, valid_o); end
            sck(bytes[i]);
        end
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL lat2_done: got done=%b busy=%b expected 1 0", done_o, busy_o); end
        checks++; if (data_o !== 32'h44332211 || strb_o !== 4'hF || last_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL lat2_word: got %h/%h/%b/%b expected 44332211/f/1/1", data_o, strb_o, last_o, valid_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL lat2_done_pulse: got %b expected 0", done_o); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat2_drain: got %b expected 0", valid_o); end
    endtask

    task automatic test_two_words();
        go(8'd6, 8'd0);
        for (int i = 0; i < 6; i++) begin
            sck(8'hA0 + 8'(i));
            tick();
            if (i == 3) begin
                checks++; if (data_o !== 32'hA3A2A1A0 || strb_o !== 4'hF || last_o !== 1'b0) begin errors++; $display("FAIL two_w0: got %h/%h/%b expected a3a2a1a0/f/0", data_o, strb_o, last_o); end
            end
        end
        ready = 1'b1;
        tick();
        checks++; if (data_o !== 32'h0000A5A4 || strb_o !== 4'h3 || last_o !== 1'b1) begin errors++; $display("FAIL two_w1: got %h/%h/%b expected 0000a5a4/3/1", data_o, strb_o, last_o); end
        tick();
        ready = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL two_drain: got %b expected 0", valid_o); end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        go(8'd20, 8'd0);
        for (int i = 0; i < 20; i++) begin
            sck(8'(i));
            if (i == 15) begin
                checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf_o); end
            end
        end
        checks++; if (ovf_o !== 1'b1 || done_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got ovf=%b done=%b expected 1 1", ovf_o, done_o); end
        go(8'd1, 8'd5);
        checks++; if (ovf_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL ovf_clear: got ovf=%b busy=%b expected 0 1", ovf_o, busy_o); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== seq_word(k) || last_o !== 1'b0) begin errors++; $display("FAIL ovf_drain%0d: got %h/%b/%b expected %h/0/1", k, data_o, last_o, valid_o, seq_word(k)); end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", valid_o); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL wait_abort: got done=%b busy=%b valid=%b expected 1 0 0", done_o, busy_o, valid_o); end
    endtask

    task automatic test_abort();
        go(8'd8, 8'd0);
        for (int i = 0; i < 5; i++) sck(8'hB0 + 8'(i));
        abort    = 1'b1;
        sck_edge = 1'b1;
        din      = 8'hB5;
        tick();
        abort    = 1'b0;
        sck_edge = 1'b0;
        checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL abort_flush: got busy=%b done=%b expected 1 0", busy_o, done_o); end
        tick();
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_done: got done=%b busy=%b expected 1 0", done_o, busy_o); end
        checks++; if (data_o !== 32'hB3B2B1B0 || strb_o !== 4'hF || last_o !== 1'b0) begin errors++; $display("FAIL abort_w0: got %h/%h/%b expected b3b2b1b0/f/0", data_o, strb_o, last_o); end
        ready = 1'b1;
        tick();
        checks++; if (data_o !== 32'h000000B4 || strb_o !== 4'h1 || last_o !== 1'b1) begin errors++; $display("FAIL abort_w1: got %h/%h/%b expected 000000b4/1/1", data_o, strb_o, last_o); end
        tick();
        ready = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_nob5: got valid=%b data=%h expected empty", valid_o, data_o); end
    endtask

    task automatic test_full_push_pop();
        int n;
        logic lastseen;
        ready = 1'b0;
        go(8'd20, 8'd0);
        for (int i = 0; i < 19; i++) sck(8'(i));
        sck_edge = 1'b1;
        din      = 8'd19;
        ready    = 1'b1;
        tick();
        sck_edge = 1'b0;
        ready    = 1'b0;
        checks++; if (ovf_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL fpp_ovf: got ovf=%b done=%b expected 0 1", ovf_o, done_o); end
        checks++; if (data_o !== seq_word(1)) begin errors++; $display("FAIL fpp_head: got %h expected %h", data_o, seq_word(1)); end
        n = 0;
        lastseen = 1'b0;
        while (valid_o && n < 10) begin
            lastseen = last_o;
            ready = 1'b1;
            tick();
            ready = 1'b0;
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL fpp_count: got %0d expected 4", n); end
        checks++; if (lastseen !== 1'b1) begin errors++; $display("FAIL fpp_last: got %b expected 1", lastseen); end
    endtask

    task automatic test_start_busy_len0();
        go(8'd0, 8'd3);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL len0_done: got done=%b busy=%b expected 1 0", done_o, busy_o); end
        tick();
        checks++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL len0_nopush: got done=%b valid=%b expected 0 0", done_o, valid_o); end
        go(8'd2, 8'd1);
        go(8'd0, 8'd0);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL busy_start: got done=%b busy=%b expected 0 1", done_o, busy_o); end
        sck(8'h99);
        sck(8'hC1);
        sck(8'hC2);
        checks++; if (done_o !== 1'b1 || data_o !== 32'h0000C2C1 || strb_o !== 4'h3 || last_o !== 1'b1) begin errors++; $display("FAIL busy_word: got done=%b %h/%h/%b expected 1 0000c2c1/3/1", done_o, data_o, strb_o, last_o); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        go(8'd8, 8'd0);
        for (int i = 0; i < 6; i++) sck(8'hD0 + 8'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || ovf_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL mrst_ctl: got busy=%b done=%b ovf=%b valid=%b expected 0 0 0 0", busy_o, done_o, ovf_o, valid_o); end
        checks++; if ({last_o, strb_o, data_o} !== 37'd0) begin errors++; $display("FAIL mrst_head: got %h expected 0", {last_o, strb_o, data_o}); end
        go(8'd3, 8'd1);
        sck(8'h55);
        sck(8'hE0);
        sck(8'hE1);
        sck(8'hE2);
        checks++; if (done_o !== 1'b1 || data_o !== 32'h00E2E1E0 || strb_o !== 4'h7 || last_o !== 1'b1) begin errors++; $display("FAIL mrst_fresh: got done=%b %h/%h/%b expected 1 00e2e1e0/7/1", done_o, data_o, strb_o, last_o); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mrst_drain: got %b expected 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_lat2();
        test_two_words();
        test_overflow();
        test_abort();
        test_full_push_pop();
        test_start_busy_len0();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_rx_capture.md
Name: psram_rx_capture

Overview:
- Read-data capture stage directly downstream of the PSRAM core's pad interface.
- Samples the 8-bit OPI input bus on each sck edge strobe, after a programmable latency (wait-state edges).
- Packs bytes little-endian into 32-bit words and buffers them in a small FIFO.
- Delivers words to the bus-side read path over a valid/ready stream with byte strobes and a last flag.

Parameters:
- FIFO_DEPTH, 4, word entries in output FIFO; power of two, >=2
- LEN_WIDTH, 8, width of byte-count input

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse: begin a read burst capture
- len_i  in  LEN_WIDTH  bytes to capture; sampled on accepted start_i
- lat_i  in  8  sck edges to skip before first data byte; sampled on accepted start_i
- abort_i  in  1  terminate current capture; FIFO contents kept
- sck_edge_i  in  1  one-cycle strobe, asserted on the clk_i cycle where psram input data is valid (core's shift/edge strobe)
- psram_io_in_i  in  8  OPI input data
- busy_o  out  1  capture in progress
- done_o  out  1  one-cycle pulse when a capture completes or aborts
- ovf_o  out  1  sticky overflow; cleared by rst_i or accepted start_i
- data_o  out  32  FIFO head word
- strb_o  out  4  valid byte lanes of data_o
- last_o  out  1  data_o is final word of burst
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i

Behaviour:
- Reset values: busy_o=0, done_o=0, ovf_o=0, valid_o=0, data_o=0, strb_o=0, last_o=0. FIFO empty, FSM IDLE, all counters 0.
- Reset is synchronous: rst_i high on any cycle forces reset values at the next edge, including mid-capture. Reset has priority over all inputs.
- FSM states: IDLE, WAIT, CAPT, FLUSH.
- IDLE:
  - start_i with len_i==0 -> done_o pulse next cycle; stays IDLE; nothing pushed.
  - start_i with len_i!=0: latch len and lat; clear ovf_o.
  - Next state is WAIT if lat_i!=0, else CAPT.
  - busy_o=1 from the following cycle.
- start_i while not IDLE: ignored.
- WAIT:
  - Each sck_edge_i decrements the latency counter; no sampling.
  - When the counter hits 0 (the strobe that decrements 1->0) -> CAPT. That edge's data is not captured.
- CAPT:
  - Each sck_edge_i writes psram_io_in_i into byte lane byte_idx of the assembly register (first byte -> [7:0]).
  - Increments byte_idx (2-bit, wraps 3->0) and decrements the remaining count.
  - When byte_idx wraps, or the remaining count reaches 0: push {word, strb, last} into the FIFO.
    - strb = lanes written.
    - last = (remaining==0).
  - After the final byte's push -> IDLE with done_o pulse; busy_o drops the same cycle done_o rises.
- FLUSH:
  - Entered from WAIT/CAPT on abort_i.
  - If the assembly register holds >=1 byte, push it with last=1 and partial strb.
  - If no bytes are held, push nothing.
  - Next cycle -> IDLE, done_o pulse.
- abort_i in IDLE: no effect.
- abort_i and sck_edge_i in the same cycle: abort wins; that byte is dropped.
- Push latency: pushed word is visible at valid_o the cycle after the push decision.
- FIFO write when full: word dropped, ovf_o set (sticky); the capture continues counting.
- Push and pop in the same cycle while full: pop is processed first, so the push succeeds and there is no overflow.
- Pop: on valid_o & ready_i the head advances. data_o/strb_o/last_o are combinational from the head entry and are zero when empty.
- Counters: remaining count is LEN_WIDTH bits; the latency counter is 8 bits; neither wraps below 0.

Decomposition:
- Shared package, added to psram_define.sv:
  - PSRAM_RX_FSM_IDLE/WAIT/CAPT/FLUSH (2-bit encodings)
  - PSRAM_RX_WORD_WIDTH=32
- Sub-module psram_rx_fifo: synchronous FIFO, width 37 ({last,strb,data}), depth FIFO_DEPTH, with push/pop/full/empty and synchronous active-high reset.
- Capture FSM, counters and assembly register stay in the top module.

Test Plan:
- lat=2, len=4, bytes 11,22,33,44 on edges 3-6 -> one word 0x44332211, strb=F, last=1; done_o one pulse; busy_o high for exactly that span.
- lat=0, len=6, bytes A0..A5 -> word0 0xA3A2A1A0 strb=F last=0; word1 0x0000A5A4 strb=3 last=1.
- FIFO_DEPTH=4, ready_i=0, len=20 -> 4 words held, ovf_o=1 after 5th push. Next start_i clears ovf_o; the held words still drain in order.
- len=8, abort_i after 5 bytes (same cycle as 6th sck_edge_i) -> word0 full, word1 holds byte5 only, strb=1, last=1; done_o pulse; 6th byte absent.
- Full FIFO with ready_i=1 on the cycle a push occurs -> no overflow, occupancy unchanged. Also: start_i while busy is ignored; len=0 gives done_o with no push.
- rst_i asserted mid-CAPT -> next cycle all outputs at reset values and FIFO empty; a fresh capture afterwards works normally.
